// File: rtl/inst_fetch.sv
// Instruction fetch unit: holds the fetch PC, looks up a direct-mapped one-word-per-line
// I-cache, requests misses from memory, and pushes {inst, pc} into the instruction queue.
module inst_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ICACHE_IDX_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic [31:0] clear_pc,
    input  logic        queue_is_full,
    output logic        IF_inst_valid,
    output logic [31:0] IF_inst,
    output logic [31:0] IF_pc,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_inst
);

    localparam int LINES = 1 << ICACHE_IDX_W;
    localparam int TAG_W = 30 - ICACHE_IDX_W;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t                  state;
    logic [31:0]             pc;
    logic [LINES-1:0]        line_valid;
    logic [TAG_W-1:0]        tag_ram  [LINES];
    logic [31:0]             data_ram [LINES];

    logic [ICACHE_IDX_W-1:0] lookup_idx;
    logic [ICACHE_IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0]        lookup_tag;
    logic                    hit;
    logic                    fill_en;

    assign lookup_idx = pc[ICACHE_IDX_W+1:2];
    assign lookup_tag = pc[31:ICACHE_IDX_W+2];
    assign fill_idx   = mem_req_addr[ICACHE_IDX_W+1:2];
    assign hit        = line_valid[lookup_idx] && (tag_ram[lookup_idx] == lookup_tag);

    // A response coincident with clear or reset, or arriving while frozen, never fills.
    assign fill_en = !rst && !clear && rdy && (state == S_WAIT) && mem_resp_valid;

    // NOTE: tag/data arrays carry no reset; line_valid alone decides whether their contents count.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_ram[fill_idx]  <= mem_req_addr[31:ICACHE_IDX_W+2];
            data_ram[fill_idx] <= mem_resp_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            state         <= S_IDLE;
            line_valid    <= '0;
            IF_inst_valid <= 1'b0;
            IF_inst       <= 32'h0;
            IF_pc         <= 32'h0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= 32'h0;
        end else if (clear) begin
            // Dropping mem_req_valid aborts any outstanding request; cache contents survive.
            pc            <= clear_pc & ~32'h3;
            state         <= S_IDLE;
            IF_inst_valid <= 1'b0;
            mem_req_valid <= 1'b0;
        end else if (rdy) begin
            // NOTE: the push strobe defaults low here so it can never repeat for one pc.
            IF_inst_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!queue_is_full) begin
                        if (hit) begin
                            IF_inst_valid <= 1'b1;
                            IF_inst       <= data_ram[lookup_idx];
                            IF_pc         <= pc;
                            pc            <= pc + 32'd4;
                        end else begin
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= pc;
                            state         <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        line_valid[fill_idx] <= 1'b1;
                        mem_req_valid        <= 1'b0;
                        state                <= S_IDLE;
                        // When full, the line is only filled and the next idle cycle hits.
                        if (!queue_is_full) begin
                            IF_inst_valid <= 1'b1;
                            IF_inst       <= mem_resp_inst;
                            IF_pc         <= pc;
                            pc            <= pc + 32'd4;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch unit; producer side of the fetch→instruction-queue interface.
- Holds the architectural fetch PC and looks up a direct-mapped, one-word-per-line I-cache.
- On a miss, requests the word from the memory controller.
- Pushes {inst, pc} into the instruction queue, honours the queue's early-full back-pressure, and redirects on clear.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- ICACHE_IDX_W, 8, I-cache index bits; 2^ICACHE_IDX_W lines, one 32-bit word each.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global ready; when low, all state is frozen
- clear  in  1  pipeline flush / redirect (mispredict, exception)
- clear_pc  in  32  redirect target, valid when clear=1
- queue_is_full  in  1  queue back-pressure; asserted with ≤2 free slots
- IF_inst_valid  out  1  one-cycle push strobe to the queue
- IF_inst  out  32  instruction word
- IF_pc  out  32  PC of IF_inst
- mem_req_valid  out  1  fetch request to the memory controller; held until response
- mem_req_addr  out  32  word-aligned fetch address
- mem_resp_valid  in  1  one-cycle response strobe
- mem_resp_inst  in  32  fetched word, valid with mem_resp_valid

Behaviour:
- Reset, and the registered outputs on reset:
  - pc=RESET_PC, state=IDLE.
  - All cache valid bits = 0.
  - IF_inst_valid=0, IF_inst=0, IF_pc=0, mem_req_valid=0, mem_req_addr=0.
- Priority per posedge:
  - 1. rst
  - 2. clear
  - 3. rdy=0: hold every register, IF_inst_valid included
  - 4. normal operation
- Cache address split:
  - index = pc[ICACHE_IDX_W+1:2]; tag = pc[31:ICACHE_IDX_W+2].
  - hit = valid[index] && tag_ram[index]==tag.
  - Lookup is combinational from pc.
- IF_inst_valid defaults to 0 every cycle unless set below; it is never high two cycles for the same pc.
- State IDLE:
  - queue_is_full=1: no push, no request, pc holds.
  - !full && hit: IF_inst_valid<=1, IF_inst<=data[index], IF_pc<=pc, pc<=pc+4. Throughput is 1 instruction per cycle.
  - !full && miss: mem_req_valid<=1, mem_req_addr<=pc, go to WAIT. No push this cycle.
- State WAIT:
  - mem_req_valid and mem_req_addr are held stable.
  - On mem_resp_valid: write data/tag/valid at index(mem_req_addr) and set mem_req_valid<=0.
    - If !queue_is_full: push {mem_resp_inst, pc}, pc<=pc+4, go to IDLE.
    - Else: fill only, go to IDLE; the next IDLE cycle hits.
  - mem_resp_valid is ignored in IDLE.
- clear, any state:
  - pc<=clear_pc, IF_inst_valid<=0, mem_req_valid<=0, state<=IDLE.
  - Cache contents are kept.
  - Dropping mem_req_valid aborts the outstanding request. The memory controller guarantees no response for an aborted request.
  - A mem_resp_valid coincident with clear is discarded and the cache is not written.
- Back-pressure margin:
  - queue_is_full is combinational in the queue and reserves 2 slots.
  - So a push launched in the cycle full rises always lands in a free slot.
- Arithmetic:
  - pc+4 is a 32-bit wrap; 32'hFFFF_FFFC+4 = 0.
  - pc[1:0] is assumed 0; clear_pc[1:0] is forced to 0.
- Simultaneous events:
  - clear && rst → reset.
  - clear && mem_resp_valid → clear wins, the response is dropped.
  - Fill and lookup never coincide, since lookup only happens in IDLE.
- Reset mid-miss: state goes to IDLE, mem_req_valid=0. The controller aborts by the same rule as clear.

Test Plan:
- Cold start, RESET_PC=0, memory returns 32'h0000_0013 after 3 cycles → mem_req_addr=0 held 3 cycles, then IF_inst_valid=1 with IF_inst=0x13, IF_pc=0, and pc=4.
- Re-run 0x0..0xC after warm-up via clear_pc=0 → 4 consecutive pushes with IF_pc 0,4,8,C; no mem_req_valid.
- queue_is_full held high for 5 cycles while hitting → no IF_inst_valid, pc stable; on release, a push resumes the next cycle with the unchanged pc.
- clear with clear_pc=0x100 during WAIT, with mem_resp_valid the same cycle → response dropped, line not filled, next request addr=0x100.
- Conflict: fill 0x0, then fetch 0x400 (same index, ICACHE_IDX_W=8) → miss, refill; a later fetch of 0x0 misses again.
- rdy low for 3 cycles with IF_inst_valid=1 → all outputs frozen; after rdy rises, exactly one further push occurs for that pc.
